// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master's FSM state encodings.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_ADDR_DATA = 2'd1,
        W_RESP      = 2'd2
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rstate_e;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-beat AXI4-Lite initiator: one-cycle local read/write requests become AXI4-Lite
// transactions; independent read and write engines.
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int unsigned AW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [AW-1:0] AMCI_WADDR,
    input  logic [31:0]   AMCI_WDATA,
    input  logic          AMCI_WRITE,
    output logic [1:0]    AMCI_WRESP,
    output logic          AMCI_WIDLE,
    input  logic [AW-1:0] AMCI_RADDR,
    input  logic          AMCI_READ,
    output logic [31:0]   AMCI_RDATA,
    output logic [1:0]    AMCI_RRESP,
    output logic          AMCI_RIDLE,
    output logic [AW-1:0] M_AXI_AWADDR,
    output logic          M_AXI_AWVALID,
    input  logic          M_AXI_AWREADY,
    output logic [2:0]    M_AXI_AWPROT,
    output logic [31:0]   M_AXI_WDATA,
    output logic [3:0]    M_AXI_WSTRB,
    output logic          M_AXI_WVALID,
    input  logic          M_AXI_WREADY,
    input  logic [1:0]    M_AXI_BRESP,
    input  logic          M_AXI_BVALID,
    output logic          M_AXI_BREADY,
    output logic [AW-1:0] M_AXI_ARADDR,
    output logic          M_AXI_ARVALID,
    input  logic          M_AXI_ARREADY,
    output logic [2:0]    M_AXI_ARPROT,
    input  logic [31:0]   M_AXI_RDATA,
    input  logic [1:0]    M_AXI_RRESP,
    input  logic          M_AXI_RVALID,
    output logic          M_AXI_RREADY
);

    wstate_e       r_wstate, w_wstate_next;
    logic [AW-1:0] r_awaddr, w_awaddr_next;
    logic [31:0]   r_wdata, w_wdata_next;
    logic          r_awvalid, w_awvalid_next;
    logic          r_wvalid, w_wvalid_next;
    logic          r_bready, w_bready_next;
    logic [1:0]    r_wresp, w_wresp_next;
    logic          w_aw_done, w_w_done;

    always_comb begin
        w_wstate_next  = r_wstate;
        w_awaddr_next  = r_awaddr;
        w_wdata_next   = r_wdata;
        w_awvalid_next = r_awvalid;
        w_wvalid_next  = r_wvalid;
        w_bready_next  = r_bready;
        w_wresp_next   = r_wresp;
        // A channel counts as done once its VALID has dropped or is being accepted now.
        w_aw_done      = !r_awvalid || M_AXI_AWREADY;
        w_w_done       = !r_wvalid || M_AXI_WREADY;
        case (r_wstate)
            W_IDLE: begin
                if (AMCI_WRITE) begin
                    w_awaddr_next  = AMCI_WADDR;
                    w_wdata_next   = AMCI_WDATA;
                    w_awvalid_next = 1'b1;
                    w_wvalid_next  = 1'b1;
                    w_wstate_next  = W_ADDR_DATA;
                end
            end
            W_ADDR_DATA: begin
                if (M_AXI_AWREADY) w_awvalid_next = 1'b0;
                if (M_AXI_WREADY)  w_wvalid_next  = 1'b0;
                if (w_aw_done && w_w_done) begin
                    w_bready_next = 1'b1;
                    w_wstate_next = W_RESP;
                end
            end
            W_RESP: begin
                if (M_AXI_BVALID) begin
                    w_wresp_next  = M_AXI_BRESP;
                    w_bready_next = 1'b0;
                    w_wstate_next = W_IDLE;
                end
            end
            default: w_wstate_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wstate  <= W_IDLE;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_wresp   <= OKAY;
        end else begin
            r_wstate  <= w_wstate_next;
            r_awaddr  <= w_awaddr_next;
            r_wdata   <= w_wdata_next;
            r_awvalid <= w_awvalid_next;
            r_wvalid  <= w_wvalid_next;
            r_bready  <= w_bready_next;
            r_wresp   <= w_wresp_next;
        end
    end

    rstate_e       r_rstate, w_rstate_next;
    logic [AW-1:0] r_araddr, w_araddr_next;
    logic          r_arvalid, w_arvalid_next;
    logic          r_rready, w_rready_next;
    logic [31:0]   r_rdata, w_rdata_next;
    logic [1:0]    r_rresp, w_rresp_next;

    always_comb begin
        w_rstate_next  = r_rstate;
        w_araddr_next  = r_araddr;
        w_arvalid_next = r_arvalid;
        w_rready_next  = r_rready;
        w_rdata_next   = r_rdata;
        w_rresp_next   = r_rresp;
        case (r_rstate)
            R_IDLE: begin
                if (AMCI_READ) begin
                    w_araddr_next  = AMCI_RADDR;
                    w_arvalid_next = 1'b1;
                    w_rstate_next  = R_ADDR;
                end
            end
            R_ADDR: begin
                if (M_AXI_ARREADY) begin
                    w_arvalid_next = 1'b0;
                    w_rready_next  = 1'b1;
                    w_rstate_next  = R_DATA;
                end
            end
            R_DATA: begin
                if (M_AXI_RVALID) begin
                    w_rdata_next  = M_AXI_RDATA;
                    w_rresp_next  = M_AXI_RRESP;
                    w_rready_next = 1'b0;
                    w_rstate_next = R_IDLE;
                end
            end
            default: w_rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rstate  <= R_IDLE;
            r_araddr  <= '0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= OKAY;
        end else begin
            r_rstate  <= w_rstate_next;
            r_araddr  <= w_araddr_next;
            r_arvalid <= w_arvalid_next;
            r_rready  <= w_rready_next;
            r_rdata   <= w_rdata_next;
            r_rresp   <= w_rresp_next;
        end
    end

    assign AMCI_WRESP    = r_wresp;
    assign AMCI_WIDLE    = (r_wstate == W_IDLE) && !AMCI_WRITE;
    assign AMCI_RDATA    = r_rdata;
    assign AMCI_RRESP    = r_rresp;
    assign AMCI_RIDLE    = (r_rstate == R_IDLE) && !AMCI_READ;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Self-checking bench for axi4_lite_master: table vectors, random transactions against a
// latency/response model, and hand sequences for concurrency and mid-transaction reset.
module tb_axi4_lite_master;
    import axi4_lite_pkg::*;

    localparam int unsigned AW = 32;

    logic          clk;
    logic          resetn;
    logic [AW-1:0] AMCI_WADDR, AMCI_RADDR;
    logic [31:0]   AMCI_WDATA, AMCI_RDATA;
    logic          AMCI_WRITE, AMCI_READ, AMCI_WIDLE, AMCI_RIDLE;
    logic [1:0]    AMCI_WRESP, AMCI_RRESP;
    logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
    logic          M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
    logic [2:0]    M_AXI_AWPROT, M_AXI_ARPROT;
    logic [31:0]   M_AXI_WDATA;
    logic [3:0]    M_AXI_WSTRB;
    logic          M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
    logic          M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
    logic [1:0]    M_AXI_BRESP = 2'd0, M_AXI_RRESP = 2'd0;
    logic [31:0]   M_AXI_RDATA = 32'd0;

    axi4_lite_master #(.AW(AW)) dut (
        .clk(clk), .resetn(resetn),
        .AMCI_WADDR(AMCI_WADDR), .AMCI_WDATA(AMCI_WDATA), .AMCI_WRITE(AMCI_WRITE),
        .AMCI_WRESP(AMCI_WRESP), .AMCI_WIDLE(AMCI_WIDLE),
        .AMCI_RADDR(AMCI_RADDR), .AMCI_READ(AMCI_READ), .AMCI_RDATA(AMCI_RDATA),
        .AMCI_RRESP(AMCI_RRESP), .AMCI_RIDLE(AMCI_RIDLE),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Slave behaviour: each channel's READY/VALID answers after a configured number of cycles.
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic [1:0]  bresp_cfg, rresp_cfg;
    logic [31:0] rdata_cfg;
    int          aw_hs, w_hs, ar_hs, wr_issued, rd_issued;
    bit          aw_hs_prev, w_hs_prev, ar_hs_prev;
    logic [AW-1:0] exp_awaddr, exp_araddr;
    logic [31:0] exp_wdata;

    typedef struct {
        bit          is_rd;
        logic [31:0] addr;
        logic [31:0] data;
        int          a;
        int          w;
        int          b;
        logic [1:0]  resp;
        int          exp_lat;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic slave_mon();
        if (M_AXI_AWVALID) begin M_AXI_AWREADY = (aw_cnt == aw_dly); aw_cnt++; end
        else begin M_AXI_AWREADY = 1'b0; aw_cnt = 0; end
        if (M_AXI_WVALID) begin M_AXI_WREADY = (w_cnt == w_dly); w_cnt++; end
        else begin M_AXI_WREADY = 1'b0; w_cnt = 0; end
        if (M_AXI_ARVALID) begin M_AXI_ARREADY = (ar_cnt == ar_dly); ar_cnt++; end
        else begin M_AXI_ARREADY = 1'b0; ar_cnt = 0; end
        if (M_AXI_BREADY) begin
            M_AXI_BVALID = (b_cnt == b_dly); M_AXI_BRESP = bresp_cfg; b_cnt++;
        end else begin M_AXI_BVALID = 1'b0; b_cnt = 0; end
        if (M_AXI_RREADY) begin
            M_AXI_RVALID = (r_cnt == r_dly); M_AXI_RDATA = rdata_cfg; M_AXI_RRESP = rresp_cfg;
            r_cnt++;
        end else begin M_AXI_RVALID = 1'b0; r_cnt = 0; end

        if (aw_hs_prev) check("aw_drop", M_AXI_AWVALID, 0);
        if (w_hs_prev)  check("w_drop", M_AXI_WVALID, 0);
        if (ar_hs_prev) check("ar_drop", M_AXI_ARVALID, 0);
        if (M_AXI_AWVALID) check("awaddr_stable", M_AXI_AWADDR, exp_awaddr);
        if (M_AXI_WVALID) begin
            check("wdata_stable", M_AXI_WDATA, exp_wdata);
            check("wstrb", M_AXI_WSTRB, 4'hF);
        end
        if (M_AXI_ARVALID) check("araddr_stable", M_AXI_ARADDR, exp_araddr);
        // BREADY/RREADY must wait until every issued address/data beat was accepted
        if (M_AXI_BREADY) begin
            check("bready_after_aw", aw_hs, wr_issued);
            check("bready_after_w", w_hs, wr_issued);
        end
        if (M_AXI_RREADY) check("rready_after_ar", ar_hs, rd_issued);

        aw_hs_prev = M_AXI_AWVALID && M_AXI_AWREADY;
        w_hs_prev  = M_AXI_WVALID && M_AXI_WREADY;
        ar_hs_prev = M_AXI_ARVALID && M_AXI_ARREADY;
        if (aw_hs_prev) aw_hs++;
        if (w_hs_prev)  w_hs++;
        if (ar_hs_prev) ar_hs++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        slave_mon();
    endtask

    function automatic int model_wr_lat(input int a, input int w, input int b);
        return 3 + ((a > w) ? a : w) + b;
    endfunction

    function automatic int model_rd_lat(input int a, input int r);
        return 3 + a + r;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int a,
                            input int w, input int b, input logic [1:0] resp, input int exp_lat);
        int lat;
        aw_dly = a; w_dly = w; b_dly = b; bresp_cfg = resp;
        exp_awaddr = addr; exp_wdata = data;
        AMCI_WADDR = addr; AMCI_WDATA = data; AMCI_WRITE = 1'b1;
        wr_issued++;
        #1;
        check("widle_comb", AMCI_WIDLE, 0);
        step();
        AMCI_WRITE = 1'b0;
        lat = 1;
        #1;
        while (!AMCI_WIDLE && lat < 200) begin step(); lat++; end
        check("wr_latency", lat, exp_lat);
        check("wresp", AMCI_WRESP, resp);
        check("aw_count", aw_hs, wr_issued);
        check("w_count", w_hs, wr_issued);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input int a,
                           input int r, input logic [1:0] resp, input int exp_lat);
        int lat;
        ar_dly = a; r_dly = r; rresp_cfg = resp; rdata_cfg = data;
        exp_araddr = addr;
        AMCI_RADDR = addr; AMCI_READ = 1'b1;
        rd_issued++;
        #1;
        check("ridle_comb", AMCI_RIDLE, 0);
        step();
        AMCI_READ = 1'b0;
        lat = 1;
        #1;
        while (!AMCI_RIDLE && lat < 200) begin step(); lat++; end
        check("rd_latency", lat, exp_lat);
        check("rdata", AMCI_RDATA, data);
        check("rresp", AMCI_RRESP, resp);
        check("ar_count", ar_hs, rd_issued);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_awvalid"}, M_AXI_AWVALID, 0);
        check({tag, "_wvalid"}, M_AXI_WVALID, 0);
        check({tag, "_bready"}, M_AXI_BREADY, 0);
        check({tag, "_arvalid"}, M_AXI_ARVALID, 0);
        check({tag, "_rready"}, M_AXI_RREADY, 0);
        check({tag, "_widle"}, AMCI_WIDLE, 1);
        check({tag, "_ridle"}, AMCI_RIDLE, 1);
    endtask

    initial begin
        int rc, wc, c;
        resetn = 1'b0;
        AMCI_WRITE = 1'b0; AMCI_READ = 1'b0;
        AMCI_WADDR = '0; AMCI_WDATA = '0; AMCI_RADDR = '0;
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        bresp_cfg = 2'd0; rresp_cfg = 2'd0; rdata_cfg = '0;
        aw_hs = 0; w_hs = 0; ar_hs = 0; wr_issued = 0; rd_issued = 0;
        aw_hs_prev = 0; w_hs_prev = 0; ar_hs_prev = 0;
        exp_awaddr = '0; exp_araddr = '0; exp_wdata = '0;

        vecs[0] = '{1'b0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 2'd0, 3};
        vecs[1] = '{1'b0, 32'h10, 32'hA5A5A5A5, 5, 1, 0, 2'd0, 8};
        vecs[2] = '{1'b1, 32'h04, 32'h12345678, 0, 0, 2, 2'd3, 5};
        vecs[3] = '{1'b0, 32'h20, 32'h00000001, 2, 0, 3, 2'd2, 8};
        vecs[4] = '{1'b1, 32'h08, 32'hCAFEF00D, 3, 0, 0, 2'd1, 6};
        vecs[5] = '{1'b0, 32'h24, 32'hFFFFFFFF, 1, 4, 1, 2'd3, 8};

        repeat (3) step();
        check_quiet("rst");
        check("rst_awaddr", M_AXI_AWADDR, 0);
        check("rst_wdata", M_AXI_WDATA, 0);
        check("rst_araddr", M_AXI_ARADDR, 0);
        check("rst_wresp", AMCI_WRESP, 0);
        check("rst_rresp", AMCI_RRESP, 0);
        check("rst_rdata", AMCI_RDATA, 0);
        check("awprot", M_AXI_AWPROT, 0);
        check("arprot", M_AXI_ARPROT, 0);
        resetn = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].is_rd)
                do_read(vecs[i].addr, vecs[i].data, vecs[i].a, vecs[i].b, vecs[i].resp,
                        vecs[i].exp_lat);
            else
                do_write(vecs[i].addr, vecs[i].data, vecs[i].a, vecs[i].w, vecs[i].b,
                         vecs[i].resp, vecs[i].exp_lat);
            step();
        end

        for (int i = 0; i < 40; i++) begin
            int a, w, b;
            logic [31:0] addr, data;
            logic [1:0] resp;
            a = int'($urandom_range(0, 4)); w = int'($urandom_range(0, 4));
            b = int'($urandom_range(0, 4));
            addr = $urandom & 32'hFFFF_FFFC; data = $urandom;
            resp = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) do_read(addr, data, a, b, resp, model_rd_lat(a, b));
            else do_write(addr, data, a, w, b, resp, model_wr_lat(a, w, b));
            if ($urandom_range(0, 1) == 1) step();
        end

        // Write and read together; B stalls 5 cycles and a second write pulse must be ignored.
        aw_dly = 0; w_dly = 0; b_dly = 5; bresp_cfg = 2'd2;
        ar_dly = 0; r_dly = 0; rresp_cfg = 2'd1; rdata_cfg = 32'h0BADF00D;
        exp_awaddr = 32'h40; exp_wdata = 32'h55AA55AA; exp_araddr = 32'h44;
        AMCI_WADDR = 32'h40; AMCI_WDATA = 32'h55AA55AA; AMCI_WRITE = 1'b1;
        AMCI_RADDR = 32'h44; AMCI_READ = 1'b1;
        wr_issued++; rd_issued++;
        step();
        AMCI_WRITE = 1'b0; AMCI_READ = 1'b0;
        rc = -1; wc = -1; c = 1;
        while (wc < 0 && c <= 30) begin
            #1;
            if (rc < 0 && AMCI_RIDLE) rc = c;
            if (AMCI_WIDLE) wc = c;
            if (wc < 0) begin
                if (c == 4) begin
                    AMCI_WADDR = 32'h99; AMCI_WDATA = 32'h11111111; AMCI_WRITE = 1'b1;
                    #1;
                    check("ignored_widle", AMCI_WIDLE, 0);
                end
                step();
                AMCI_WRITE = 1'b0;
                c++;
            end
        end
        check("conc_rd_cycle", rc, 3);
        check("conc_wr_cycle", wc, 8);
        check("conc_rdata", AMCI_RDATA, 32'h0BADF00D);
        check("conc_rresp", AMCI_RRESP, 2'd1);
        check("conc_wresp", AMCI_WRESP, 2'd2);
        check("conc_aw_count", aw_hs, wr_issued);
        check("conc_awaddr", M_AXI_AWADDR, 32'h40);
        step();

        // Reset while the write engine waits on B.
        aw_dly = 0; w_dly = 0; b_dly = 100;
        exp_awaddr = 32'h50; exp_wdata = 32'h77;
        AMCI_WADDR = 32'h50; AMCI_WDATA = 32'h77; AMCI_WRITE = 1'b1;
        wr_issued++;
        step();
        AMCI_WRITE = 1'b0;
        step();
        check("in_wresp_bready", M_AXI_BREADY, 1);
        resetn = 1'b0;
        step();
        check_quiet("rst_wresp");
        resetn = 1'b1;
        step();

        // Reset while the read engine waits on ARREADY.
        ar_dly = 100; exp_araddr = 32'h60;
        AMCI_RADDR = 32'h60; AMCI_READ = 1'b1;
        rd_issued++;
        step();
        AMCI_READ = 1'b0;
        check("in_raddr_arvalid", M_AXI_ARVALID, 1);
        resetn = 1'b0;
        step();
        check_quiet("rst_raddr");
        rd_issued = ar_hs;
        resetn = 1'b1;
        step();

        do_write(32'h70, 32'h13572468, 0, 0, 0, 2'd0, 3);
        do_read(32'h74, 32'h2468ACE0, 0, 0, 2'd0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
